// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file write-back widths and requester ids
package regfile_pkg;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREG     = 2 ** AW;
  localparam int NREQ     = 3;
  localparam int REG_ZERO = 0;
  localparam int WB_ALU   = 0;
  localparam int WB_MEM   = 1;
  localparam int WB_MDU   = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over NREQ requesters, pointer moves past each winner
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic found;
  int j;
  // first requester at or above the pointer (wrapping) wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end
    end
    ptr_d = advance ? (grant_idx == IW'(NREQ - 1) ? '0 : grant_idx + 1'b1) : ptr_q;
  end
  // pointer register
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among write-back sources and tracks pending writes
module regfile_wb_arbiter #(
  parameter int NREQ = regfile_pkg::NREQ,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_addr,
  output logic               issue_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [1:0]         grant_id,
  output logic [2**AW-1:0]   pending
);
  import regfile_pkg::REG_ZERO;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] gidx;
  logic accept;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  logic [1:0] grant_id_q;
  logic [2**AW-1:0] pending_q, pending_d;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (gidx)
  );
  assign req_ready   = reset ? grant : '0;
  assign accept      = |req_ready;
  assign wa          = req_addr[gidx*AW +: AW];
  assign wd          = req_data[gidx*DW +: DW];
  assign issue_ready = issue_valid & ~pending_q[issue_addr] & reset;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  // retire clears, claim sets afterwards so a same-edge claim wins; r0 is never tracked
  always_comb begin
    pending_d = pending_q;
    if (accept && wa != AW'(REG_ZERO)) pending_d[wa] = 1'b0;
    if (issue_ready && issue_addr != AW'(REG_ZERO)) pending_d[issue_addr] = 1'b1;
  end
  // one-cycle write stage onto the register-file port, plus scoreboard state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q   <= accept && wa != AW'(REG_ZERO);
      pending_q <= pending_d;
      if (accept) begin
        rf_waddr_q <= wa;
        rf_wdata_q <= wd;
        grant_id_q <= 2'(gidx);
      end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the write-back arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0] req_ready;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic issue_valid = 1'b0;
  logic [4:0] issue_addr = '0;
  logic issue_ready, rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0] grant_id;
  logic [31:0] pending;
  int n_tests = 0, n_fail = 0;
  int m_ptr = 0, m_last_g = -1;
  logic [31:0] m_pend = '0;
  logic m_we = 1'b0;
  logic [4:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [1:0] m_gid = '0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .issue_ready(issue_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < 3; k++)
      if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    int g;
    logic ir;
    logic [4:0] a;
    g = exp_grant();
    ir = issue_valid && (issue_addr == 5'd0 || !m_pend[issue_addr]);
    @(negedge clk);
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : 64'(1) << g);
    chk("issue_ready", 64'(issue_ready), 64'(ir));
    @(posedge clk);
    m_last_g = g;
    if (g >= 0) begin
      a = req_addr[g*5 +: 5];
      m_ptr = (g + 1) % 3;
      if (a != 5'd0) m_pend[a] = 1'b0;
      m_we = (a != 5'd0);
      m_waddr = a;
      m_wdata = req_data[g*32 +: 32];
      m_gid = 2'(g);
    end else m_we = 1'b0;
    if (ir && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("pending", 64'(pending), 64'(m_pend));
    if (m_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
    end
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    logic [4:0] rr_addr [4];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
    rr_addr = '{5'd5, 5'd6, 5'd7, 5'd5};
    #12;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_pending", 64'(pending), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    // round-robin with all three requesting
    set_req(0, 5'd5, 32'hA5); set_req(1, 5'd6, 32'hB6); set_req(2, 5'd7, 32'hC7);
    req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rr_gid", 64'(grant_id), 64'(rr_exp[n]));
      chk("rr_waddr", 64'(rf_waddr), 64'(rr_addr[n]));
    end
    tick();
    // asynchronous reset mid-stream
    #3;
    reset = 1'b0;
    #1;
    chk("arst_rf_we", 64'(rf_we), 64'd0);
    chk("arst_pending", 64'(pending), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    m_ptr = 0; m_pend = '0; m_we = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold_ready", 64'(req_ready), 64'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_gid", 64'(grant_id), 64'd0);
    chk("post_reset_we", 64'(rf_we), 64'd1);
    req_valid = '0;
    tick();
    // single write latency
    set_req(0, 5'd9, 32'hDEADBEEF);
    req_valid = 3'b001;
    tick();
    chk("lat_we", 64'(rf_we), 64'd1);
    chk("lat_data", 64'(rf_wdata), 64'hDEADBEEF);
    req_valid = '0;
    tick();
    chk("lat_we_drop", 64'(rf_we), 64'd0);
    // write and claim of r0
    set_req(1, 5'd0, 32'h1);
    req_valid = 3'b010;
    tick();
    chk("r0_we", 64'(rf_we), 64'd0);
    req_valid = '0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    chk("r0_pending", 64'(pending[0]), 64'd0);
    // scoreboard claim / retire
    issue_addr = 5'd3;
    tick();
    chk("sb_set", 64'(pending[3]), 64'd1);
    tick();
    set_req(2, 5'd3, 32'h33);
    req_valid = 3'b100;
    tick();
    chk("sb_retire", 64'(pending[3]), 64'd0);
    req_valid = '0;
    tick();
    chk("sb_reclaim", 64'(pending[3]), 64'd1);
    // same-register conflict, pointer back at 0
    issue_addr = 5'd4;
    tick();
    issue_valid = 1'b0;
    set_req(0, 5'd4, 32'd1); set_req(1, 5'd4, 32'd2);
    req_valid = 3'b011;
    tick();
    chk("conf_first", 64'(rf_wdata), 64'd1);
    chk("conf_pend", 64'(pending[4]), 64'd0);
    req_valid = 3'b010;
    tick();
    chk("conf_second", 64'(rf_wdata), 64'd2);
    chk("conf_addr", 64'(rf_waddr), 64'd4);
    req_valid = '0;
    tick();
    // random traffic; an unaccepted request holds its address and data
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        if (!(req_valid[i] && m_last_g != i)) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
        end
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 31));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
